// File: rtl/arm_spi_loader_if.sv
// SPI + SRAM write bus of the bootstrap loader.
//   slave  : the loader (samples sclk/ss_b/mosi, drives miso and the SRAM bus).
//   master : the ARM / SRAM-mux side.
// Signals: sclk, ss_b, mosi, miso (SPI mode 0); booting, ram_cs_b, ram_oe_b,
// ram_we_b, ram_a, ram_d (SRAM write bus); progress, overrun (status).
interface arm_spi_loader_if #(
    parameter int unsigned ADDR_WIDTH = 18
);
    logic                  sclk;
    logic                  ss_b;
    logic                  mosi;
    logic                  miso;
    logic                  booting;
    logic                  ram_cs_b;
    logic                  ram_oe_b;
    logic                  ram_we_b;
    logic [ADDR_WIDTH-1:0] ram_a;
    logic [7:0]            ram_d;
    logic [7:0]            progress;
    logic                  overrun;

    modport slave (
        input  sclk, ss_b, mosi,
        output miso, booting, ram_cs_b, ram_oe_b, ram_we_b, ram_a, ram_d, progress, overrun
    );

    modport master (
        output sclk, ss_b, mosi,
        input  miso, booting, ram_cs_b, ram_oe_b, ram_we_b, ram_a, ram_d, progress, overrun
    );
endinterface

// File: rtl/arm_spi_loader.sv
// SPI slave that receives the ROM image from the ARM during bootstrap and turns it into
// byte writes on the external SRAM bus.
// Ports:
//   clk     : system clock
//   n_reset : asynchronous active-low reset
//   bus     : SPI inputs (sclk/ss_b/mosi, asynchronous), miso, SRAM write bus,
//             booting (CPU held in reset / loader owns SRAM), progress, sticky overrun.
// Frame: CMD_WRITE A2 A1 A0 data... writes bytes from address {A2,A1,A0};
//        CMD_DONE followed by ss_b rising drops booting until reset.
module arm_spi_loader #(
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned WE_CYCLES  = 4,
    parameter logic [7:0]  CMD_WRITE  = 8'hA5,
    parameter logic [7:0]  CMD_DONE   = 8'h5A
) (
    input logic             clk,
    input logic             n_reset,
    arm_spi_loader_if.slave bus
);

    localparam int unsigned CntW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle, StCmd, StAddr2, StAddr1, StAddr0, StData, StIgnore, StDonePend
    } frame_e;

    typedef enum logic [1:0] {WIdle, WSetup, WPulse, WHold} wr_e;

    // Synchronisers; the third stage of sclk/ss_b is only the previous value for edge detect.
    logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic ss_s1_q, ss_s2_q, ss_s3_q;
    logic mosi_s1_q, mosi_s2_q;

    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic [7:0]            rx_byte_q, rx_byte_d;
    logic [7:0]            tx_q, tx_d;
    logic                  byte_valid_q, byte_valid_d;
    frame_e                frame_q, frame_d;
    logic [15:0]           addr_hi_q, addr_hi_d;
    logic                  booting_q, booting_d;
    wr_e                   wr_q, wr_d;
    logic [CntW-1:0]       we_cnt_q, we_cnt_d;
    logic                  cs_b_q, cs_b_d;
    logic                  we_b_q, we_b_d;
    logic [ADDR_WIDTH-1:0] ram_a_q, ram_a_d;
    logic [7:0]            ram_d_q, ram_d_d;
    logic                  overrun_q, overrun_d;

    logic sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic load_addr, data_valid;

    assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
    assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
    assign ss_rise   = ss_s2_q & ~ss_s3_q;
    assign ss_fall   = ~ss_s2_q & ss_s3_q;

    // Byte assembly and miso shifter
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_byte_d    = rx_byte_q;
        tx_d         = tx_q;
        byte_valid_d = 1'b0;
        if (ss_s2_q) begin
            // Deselected: drop any partial byte and forget the frame's echo history.
            bit_cnt_d = 3'd0;
            shift_d   = 8'h00;
            rx_byte_d = 8'h00;
            tx_d      = 8'h00;
        end else begin
            if (sclk_rise) begin
                shift_d   = {shift_q[6:0], mosi_s2_q};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_valid_d = 1'b1;
                    rx_byte_d    = {shift_q[6:0], mosi_s2_q};
                end
            end
            if (sclk_fall) begin
                // The fall that closes a byte (counter back at 0) loads the byte just
                // received, so its MSB is on miso for the first rise of the next byte.
                if (bit_cnt_q == 3'd0) begin
                    tx_d = rx_byte_q;
                end else begin
                    tx_d = {tx_q[6:0], 1'b0};
                end
            end
        end
    end

    // Frame parser
    always_comb begin
        frame_d    = frame_q;
        addr_hi_d  = addr_hi_q;
        booting_d  = booting_q;
        load_addr  = 1'b0;
        data_valid = 1'b0;
        if (ss_rise) begin
            frame_d = StIdle;
            if (frame_q == StDonePend) begin
                booting_d = 1'b0;
            end
        end else begin
            unique case (frame_q)
                StIdle: begin
                    if (ss_fall) frame_d = StCmd;
                end
                StCmd: begin
                    if (byte_valid_q) begin
                        if (rx_byte_q == CMD_WRITE) begin
                            frame_d = StAddr2;
                        end else if (rx_byte_q == CMD_DONE) begin
                            frame_d = StDonePend;
                        end else begin
                            frame_d = StIgnore;
                        end
                    end
                end
                StAddr2: begin
                    if (byte_valid_q) begin
                        addr_hi_d[15:8] = rx_byte_q;
                        frame_d         = StAddr1;
                    end
                end
                StAddr1: begin
                    if (byte_valid_q) begin
                        addr_hi_d[7:0] = rx_byte_q;
                        frame_d        = StAddr0;
                    end
                end
                StAddr0: begin
                    if (byte_valid_q) begin
                        load_addr = 1'b1;
                        frame_d   = StData;
                    end
                end
                StData: begin
                    data_valid = byte_valid_q;
                end
                StIgnore, StDonePend: begin
                end
                default: frame_d = StIdle;
            endcase
        end
    end

    // Write engine
    always_comb begin
        wr_d      = wr_q;
        we_cnt_d  = we_cnt_q;
        cs_b_d    = cs_b_q;
        we_b_d    = we_b_q;
        ram_a_d   = ram_a_q;
        ram_d_d   = ram_d_q;
        overrun_d = overrun_q;
        unique case (wr_q)
            WIdle: begin
                if (data_valid && booting_q) begin
                    ram_d_d = rx_byte_q;
                    cs_b_d  = 1'b0;
                    wr_d    = WSetup;
                end
            end
            WSetup: begin
                we_b_d   = 1'b0;
                we_cnt_d = '0;
                wr_d     = WPulse;
            end
            WPulse: begin
                if (we_cnt_q == CntW'(WE_CYCLES - 1)) begin
                    we_b_d = 1'b1;
                    cs_b_d = 1'b1;
                    wr_d   = WHold;
                end else begin
                    we_cnt_d = we_cnt_q + 1'b1;
                end
            end
            WHold: begin
                ram_a_d = ram_a_q + ADDR_WIDTH'(1);
                wr_d    = WIdle;
            end
            default: wr_d = WIdle;
        endcase
        // Engine busy: the byte is lost and the address does not advance for it.
        if (data_valid && booting_q && (wr_q != WIdle)) begin
            overrun_d = 1'b1;
        end
        if (load_addr) begin
            ram_a_d = ADDR_WIDTH'({addr_hi_q, rx_byte_q});
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sclk_s1_q    <= 1'b0;
            sclk_s2_q    <= 1'b0;
            sclk_s3_q    <= 1'b0;
            ss_s1_q      <= 1'b1;
            ss_s2_q      <= 1'b1;
            ss_s3_q      <= 1'b1;
            mosi_s1_q    <= 1'b0;
            mosi_s2_q    <= 1'b0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            rx_byte_q    <= 8'h00;
            tx_q         <= 8'h00;
            byte_valid_q <= 1'b0;
            frame_q      <= StIdle;
            addr_hi_q    <= 16'h0000;
            booting_q    <= 1'b1;
            wr_q         <= WIdle;
            we_cnt_q     <= '0;
            cs_b_q       <= 1'b1;
            we_b_q       <= 1'b1;
            ram_a_q      <= '0;
            ram_d_q      <= 8'h00;
            overrun_q    <= 1'b0;
        end else begin
            sclk_s1_q    <= bus.sclk;
            sclk_s2_q    <= sclk_s1_q;
            sclk_s3_q    <= sclk_s2_q;
            ss_s1_q      <= bus.ss_b;
            ss_s2_q      <= ss_s1_q;
            ss_s3_q      <= ss_s2_q;
            mosi_s1_q    <= bus.mosi;
            mosi_s2_q    <= mosi_s1_q;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_byte_q    <= rx_byte_d;
            tx_q         <= tx_d;
            byte_valid_q <= byte_valid_d;
            frame_q      <= frame_d;
            addr_hi_q    <= addr_hi_d;
            booting_q    <= booting_d;
            wr_q         <= wr_d;
            we_cnt_q     <= we_cnt_d;
            cs_b_q       <= cs_b_d;
            we_b_q       <= we_b_d;
            ram_a_q      <= ram_a_d;
            ram_d_q      <= ram_d_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.miso     = ~ss_s2_q & tx_q[7];
    assign bus.booting  = booting_q;
    assign bus.ram_cs_b = cs_b_q;
    assign bus.ram_oe_b = 1'b1;
    assign bus.ram_we_b = we_b_q;
    assign bus.ram_a    = ram_a_q;
    assign bus.ram_d    = ram_d_q;
    assign bus.progress = ram_a_q[ADDR_WIDTH-1 -: 8];
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_arm_spi_loader.sv
// Self-checking bench for arm_spi_loader: randomized SPI frames against a frame-level model.
module tb_arm_spi_loader;

    localparam int unsigned AW = 18;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk = ~clk;

    // sel=0 routes the SPI driver to DUT A (WE_CYCLES=4), sel=1 to DUT B (WE_CYCLES=40).
    logic sel = 1'b0;
    logic sclk_drv = 1'b0, ss_drv = 1'b1, mosi_drv = 1'b0;

    arm_spi_loader_if #(.ADDR_WIDTH(AW)) bus_a ();
    arm_spi_loader_if #(.ADDR_WIDTH(AW)) bus_b ();

    assign bus_a.sclk = sel ? 1'b0 : sclk_drv;
    assign bus_a.ss_b = sel ? 1'b1 : ss_drv;
    assign bus_a.mosi = sel ? 1'b0 : mosi_drv;
    assign bus_b.sclk = sel ? sclk_drv : 1'b0;
    assign bus_b.ss_b = sel ? ss_drv : 1'b1;
    assign bus_b.mosi = sel ? mosi_drv : 1'b0;

    arm_spi_loader #(.ADDR_WIDTH(AW), .WE_CYCLES(4)) u_dut_a (
        .clk(clk), .n_reset(n_reset), .bus(bus_a)
    );
    arm_spi_loader #(.ADDR_WIDTH(AW), .WE_CYCLES(40)) u_dut_b (
        .clk(clk), .n_reset(n_reset), .bus(bus_b)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
        int            len;
        bit            ok;
    } wr_t;

    wr_t wr_a[$], wr_b[$], exp_w[$];
    logic [7:0] ftx[$], frx[$];

    // Frame-level reference state
    logic [AW-1:0] m_addr = '0;
    bit            m_boot = 1'b1;

    // SRAM-side monitors: one record per ram_we_b low pulse
    bit  a_act = 0, b_act = 0, a_prev_cs = 0, b_prev_cs = 0;
    wr_t a_cur, b_cur;
    int  a_cs_cnt = 0;

    always @(negedge clk) begin
        if (!n_reset) begin
            a_act = 0;
        end else if (!bus_a.ram_we_b) begin
            if (!a_act) begin
                a_act = 1; a_cur.a = bus_a.ram_a; a_cur.d = bus_a.ram_d; a_cur.len = 1;
                a_cur.ok = a_prev_cs && !bus_a.ram_cs_b;
            end else begin
                a_cur.len++;
                if (bus_a.ram_a !== a_cur.a || bus_a.ram_d !== a_cur.d || bus_a.ram_cs_b !== 1'b0)
                    a_cur.ok = 0;
            end
        end else if (a_act) begin
            a_act = 0;
            if (bus_a.ram_a !== a_cur.a || bus_a.ram_cs_b !== 1'b1) a_cur.ok = 0;
            wr_a.push_back(a_cur);
        end
        if (!bus_a.ram_cs_b) a_cs_cnt++;
        a_prev_cs = !bus_a.ram_cs_b;
    end

    always @(negedge clk) begin
        if (!n_reset) begin
            b_act = 0;
        end else if (!bus_b.ram_we_b) begin
            if (!b_act) begin
                b_act = 1; b_cur.a = bus_b.ram_a; b_cur.d = bus_b.ram_d; b_cur.len = 1;
                b_cur.ok = b_prev_cs && !bus_b.ram_cs_b;
            end else begin
                b_cur.len++;
                if (bus_b.ram_a !== b_cur.a || bus_b.ram_d !== b_cur.d || bus_b.ram_cs_b !== 1'b0)
                    b_cur.ok = 0;
            end
        end else if (b_act) begin
            b_act = 0;
            if (bus_b.ram_a !== b_cur.a || bus_b.ram_cs_b !== 1'b1) b_cur.ok = 0;
            wr_b.push_back(b_cur);
        end
        b_prev_cs = !bus_b.ram_cs_b;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- SPI master ----------------
    task automatic spi_begin();
        ss_drv = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] b, input int half, output logic [7:0] r);
        for (int i = 7; i >= 0; i--) begin
            mosi_drv = b[i];
            repeat (half) @(negedge clk);
            r[i] = sel ? bus_b.miso : bus_a.miso;
            sclk_drv = 1'b1;
            repeat (half) @(negedge clk);
            sclk_drv = 1'b0;
        end
    endtask

    task automatic spi_end(input int half);
        repeat (half) @(negedge clk);
        ss_drv   = 1'b1;
        mosi_drv = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic spi_frame(input int half);
        logic [7:0] r;
        frx.delete();
        spi_begin();
        foreach (ftx[k]) begin
            spi_byte(ftx[k], half, r);
            frx.push_back(r);
        end
        spi_end(half);
    endtask

    // Expected effect of a whole frame on DUT A
    task automatic model_frame();
        wr_t e;
        if (ftx.size() == 0) return;
        if (ftx[0] == 8'hA5) begin
            if (ftx.size() >= 4) begin
                m_addr = AW'({ftx[1], ftx[2], ftx[3]});
                for (int k = 4; k < ftx.size(); k++) begin
                    if (m_boot) begin
                        e.a = m_addr; e.d = ftx[k]; e.len = 4; e.ok = 1;
                        exp_w.push_back(e);
                        m_addr = m_addr + 1'b1;
                    end
                end
            end
        end else if (ftx[0] == 8'h5A) begin
            m_boot = 1'b0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus_a.booting !== 1'b1) begin errors++;
            $display("FAIL reset booting got %b want 1", bus_a.booting); end
        checks++; if (bus_a.miso !== 1'b0) begin errors++;
            $display("FAIL reset miso got %b want 0", bus_a.miso); end
        checks++; if (bus_a.overrun !== 1'b0) begin errors++;
            $display("FAIL reset overrun got %b want 0", bus_a.overrun); end
        checks++; if ({bus_a.ram_cs_b, bus_a.ram_oe_b, bus_a.ram_we_b} !== 3'b111) begin errors++;
            $display("FAIL reset cs/oe/we got %b%b%b want 111",
                     bus_a.ram_cs_b, bus_a.ram_oe_b, bus_a.ram_we_b); end
        checks++; if (bus_a.ram_a !== '0) begin errors++;
            $display("FAIL reset ram_a got %h want 0", bus_a.ram_a); end
        checks++; if (bus_a.ram_d !== 8'h00) begin errors++;
            $display("FAIL reset ram_d got %h want 00", bus_a.ram_d); end
        checks++; if (bus_a.progress !== 8'h00) begin errors++;
            $display("FAIL reset progress got %h want 00", bus_a.progress); end
        n_reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Drive ftx into DUT A and compare writes, echo, address and status with the model.
    task automatic test_frame(input string name);
        exp_w.delete();
        wr_a.delete();
        model_frame();
        spi_frame(8);
        checks++; if (wr_a.size() != exp_w.size()) begin errors++;
            $display("FAIL %s write count got %0d want %0d", name, wr_a.size(), exp_w.size()); end
        for (int k = 0; k < exp_w.size() && k < wr_a.size(); k++) begin
            checks++;
            if (wr_a[k].a !== exp_w[k].a || wr_a[k].d !== exp_w[k].d ||
                wr_a[k].len != exp_w[k].len || !wr_a[k].ok) begin
                errors++;
                $display("FAIL %s write%0d got a=%h d=%h we_len=%0d stable=%0d want a=%h d=%h we_len=%0d stable=1",
                         name, k, wr_a[k].a, wr_a[k].d, wr_a[k].len, wr_a[k].ok,
                         exp_w[k].a, exp_w[k].d, exp_w[k].len);
            end
        end
        for (int k = 0; k < frx.size(); k++) begin
            logic [7:0] want;
            want = (k == 0) ? 8'h00 : ftx[k-1];
            checks++; if (frx[k] !== want) begin errors++;
                $display("FAIL %s miso byte%0d got %h want %h", name, k, frx[k], want); end
        end
        checks++; if (bus_a.ram_a !== m_addr || bus_a.progress !== m_addr[AW-1:AW-8]) begin
            errors++;
            $display("FAIL %s ram_a/progress got %h/%h want %h/%h", name, bus_a.ram_a,
                     bus_a.progress, m_addr, m_addr[AW-1:AW-8]); end
        checks++; if (bus_a.booting !== m_boot || bus_a.overrun !== 1'b0) begin errors++;
            $display("FAIL %s booting/overrun got %b/%b want %b/0", name, bus_a.booting,
                     bus_a.overrun, m_boot); end
    endtask

    task automatic test_write();
        ftx = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
        test_frame("write");
    endtask

    task automatic test_wrap();
        ftx = '{8'hA5, 8'h03, 8'hFF, 8'hFF, 8'hAA, 8'hBB};
        test_frame("wrap");
    endtask

    task automatic test_echo();
        ftx = '{8'hA5, 8'h01, 8'h02};
        test_frame("echo");
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            int n;
            ftx.delete();
            if ($urandom_range(0, 9) < 7) ftx.push_back(8'hA5);
            else ftx.push_back(8'h30 + 8'($urandom_range(0, 15)));
            for (int k = 0; k < 3; k++) ftx.push_back(8'($urandom));
            n = $urandom_range(0, 4);
            for (int k = 0; k < n; k++) ftx.push_back(8'($urandom));
            test_frame($sformatf("random%0d", f));
        end
    endtask

    task automatic test_short_frame();
        ftx = '{8'hA5, 8'h00, 8'h01};
        test_frame("short");
    endtask

    // DUT B: bytes every 32 clk against a 43-clk write cycle
    task automatic test_overrun();
        logic [AW-1:0] base;
        int            last;
        int            n_acc;
        wr_t           e;
        sel = 1'b1;
        exp_w.delete();
        wr_b.delete();
        base = AW'(24'h000200);
        ftx = '{8'hA5, 8'h00, 8'h02, 8'h00};
        for (int k = 0; k < 6; k++) ftx.push_back(8'($urandom));
        last = -1000;
        n_acc = 0;
        for (int k = 0; k < 6; k++) begin
            if (32 * k >= last + 40 + 3) begin
                e.a = base + AW'(n_acc); e.d = ftx[4+k]; e.len = 40; e.ok = 1;
                exp_w.push_back(e);
                n_acc++;
                last = 32 * k;
            end
        end
        spi_frame(2);
        repeat (60) @(negedge clk);
        checks++; if (bus_b.overrun !== 1'b1) begin errors++;
            $display("FAIL overrun flag got %b want 1", bus_b.overrun); end
        checks++; if (wr_b.size() != exp_w.size()) begin errors++;
            $display("FAIL overrun write count got %0d want %0d", wr_b.size(), exp_w.size()); end
        for (int k = 0; k < exp_w.size() && k < wr_b.size(); k++) begin
            checks++;
            if (wr_b[k].a !== exp_w[k].a || wr_b[k].d !== exp_w[k].d ||
                wr_b[k].len != exp_w[k].len || !wr_b[k].ok) begin
                errors++;
                $display("FAIL overrun write%0d got a=%h d=%h we_len=%0d want a=%h d=%h we_len=%0d",
                         k, wr_b[k].a, wr_b[k].d, wr_b[k].len, exp_w[k].a, exp_w[k].d, exp_w[k].len);
            end
        end
        checks++; if (bus_b.ram_a !== base + AW'(n_acc)) begin errors++;
            $display("FAIL overrun final ram_a got %h want %h", bus_b.ram_a, base + AW'(n_acc)); end
        sel = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] r;
        int         c;
        bit         seen;
        spi_begin();
        spi_byte(8'hA5, 8, r);
        spi_byte(8'h00, 8, r);
        spi_byte(8'h00, 8, r);
        spi_byte(8'h40, 8, r);
        seen = 0;
        fork
            spi_byte(8'h77, 8, r);
            begin
                c = 0;
                while (bus_a.ram_we_b === 1'b1 && c < 400) begin
                    @(negedge clk);
                    c++;
                end
                seen = (bus_a.ram_we_b === 1'b0);
                if (seen) begin
                    #2 n_reset = 1'b0;
                    #1;
                    checks++; if (bus_a.ram_we_b !== 1'b1 || bus_a.ram_cs_b !== 1'b1) begin
                        errors++;
                        $display("FAIL abort we/cs got %b/%b want 1/1",
                                 bus_a.ram_we_b, bus_a.ram_cs_b); end
                    checks++; if (bus_a.booting !== 1'b1 || bus_a.ram_a !== '0) begin errors++;
                        $display("FAIL abort booting/ram_a got %b/%h want 1/0",
                                 bus_a.booting, bus_a.ram_a); end
                end
            end
        join
        checks++; if (!seen) begin errors++;
            $display("FAIL abort timeout waiting for ram_we_b low got %b want 0", bus_a.ram_we_b);
        end
        ss_drv = 1'b1;
        mosi_drv = 1'b0;
        n_reset = 1'b0;
        repeat (5) @(negedge clk);
        n_reset = 1'b1;
        repeat (5) @(negedge clk);
        wr_a.delete();
        m_addr = '0;
        m_boot = 1'b1;
    endtask

    task automatic test_done();
        logic [7:0] r;
        int         cs_before;
        spi_begin();
        spi_byte(8'h5A, 8, r);
        repeat (8) @(negedge clk);
        ss_drv = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus_a.booting !== 1'b1) begin errors++;
            $display("FAIL done booting early got %b want 1", bus_a.booting); end
        @(negedge clk);
        checks++; if (bus_a.booting !== 1'b0) begin errors++;
            $display("FAIL done booting got %b want 0", bus_a.booting); end
        repeat (12) @(negedge clk);
        m_boot = 1'b0;
        cs_before = a_cs_cnt;
        wr_a.delete();
        ftx = '{8'hA5, 8'h00, 8'h00, 8'h10, 8'h5C, 8'hC3};
        spi_frame(8);
        checks++; if (a_cs_cnt != cs_before || wr_a.size() != 0) begin errors++;
            $display("FAIL post-done cs cycles/writes got %0d/%0d want 0/0",
                     a_cs_cnt - cs_before, wr_a.size()); end
        checks++; if (bus_a.booting !== 1'b0) begin errors++;
            $display("FAIL post-done booting got %b want 0", bus_a.booting); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_wrap();
        test_echo();
        test_random();
        test_short_frame();
        test_overrun();
        test_reset_mid_write();
        test_write();
        test_done();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
